fetch_prefetch_queue: RTL
=========================

// Module: fetch_prefetch_queue
// PURPOSE
//   Instruction-fetch front end. Sits between instruction memory and decode/branch logic.
//   Holds the fetch PC and issues word requests to imem over a valid/ready handshake.
//   Buffers returned words with their PCs in a small FIFO and hands them to decode.
//   A redirect from branch/jump resolution flushes the FIFO and squashes any in-flight fetch.
// PARAMETERS
//   RESET_PC  32'h0000_0000  fetch PC loaded on reset
//   DEPTH     2              FIFO entries (power of 2, >=2)
// PORTS
//   clk             in   1   clock, rising edge
//   reset           in   1   asynchronous, active-high reset
//   imem_req_valid  out  1   fetch request valid
//   imem_req_ready  in   1   imem accepts request
//   imem_req_addr   out  32  word address of request (bits [1:0] always 0)
//   imem_rsp_valid  in   1   response valid; at most 1 outstanding, no backpressure
//   imem_rsp_data   in   32  instruction word
//   instr_valid     out  1   FIFO head valid to decode
//   instr_ready     in   1   decode consumes head
//   instr_data      out  32  head instruction word
//   instr_pc        out  32  PC of head instruction
//   redirect_valid  in   1   branch/jump taken: restart fetch
//   redirect_pc     in   32  target; bits [1:0] ignored (treated as 0)
//   perf_fetched    out  32  (FETCH_PERF_EN only) words pushed into FIFO
//   perf_squashed   out  32  (FETCH_PERF_EN only) words dropped by redirect
// BEHAVIOUR
//   Reset: fetch_pc=RESET_PC, FIFO empty, state=REQ; all outputs 0 while reset is high.
//   FSM: REQ -> WAIT on req handshake; WAIT -> REQ on rsp; DRAIN -> REQ on rsp (rsp dropped).
//   REQ: imem_req_valid=1 iff (FIFO count + outstanding) < DEPTH; addr=fetch_pc.
//   Req handshake (valid&ready): the request's PC is latched as the in-flight PC; fetch_pc+=4, wrapping mod 2^32.
//   WAIT rsp: push {imem_rsp_data, in-flight PC} into the FIFO; the FIFO never overflows by construction.
//   FIFO: registered output, no bypass; rsp in cycle N -> instr_valid in N+1.
//   Minimum latency: req accepted at N, rsp at N+1, instr_valid at N+2.
//   Pop on instr_valid&instr_ready; simultaneous push+pop keeps the count.
//   Full: no new request issued; empty: instr_valid=0, data/pc hold last values.
//   Redirect (has priority over all other updates):
//     - Flush the FIFO and set fetch_pc={redirect_pc[31:2],2'b00}; instr_valid=0 next cycle.
//     - A pop handshaking in the same cycle completes (that instruction is consumed).
//     - A response present in the same cycle is discarded; state -> REQ.
//     - In WAIT with no response: state -> DRAIN and the next response is dropped.
//     - Request handshaking in the same cycle: the request counts as in-flight -> DRAIN.
//     - In DRAIN: update fetch_pc and stay in DRAIN.
//     - In REQ with no handshake: the new address is driven from the next cycle.
//   Reset mid-operation: immediate return to the reset state; an in-flight rsp is ignored.
// CONFIGURATION
//   FETCH_PERF_EN defined:
//     - perf_fetched increments on every FIFO push.
//     - perf_squashed adds the flushed FIFO count, +1 per response dropped on redirect or in DRAIN.
//     - Both reset to 0 and wrap mod 2^32.
//   FETCH_PERF_EN undefined: perf ports and counters are absent; all other behaviour is identical.
// TESTING
//   1. Reset, imem ready=1, 1-cycle rsp, instr_ready=1 -> addrs 0,4,8..., instr_pc 0,4,8 in order,
//      first instr_valid 2 cycles after the first handshake.
//   2. instr_ready=0 -> exactly 2 requests issued (DEPTH=2), then req_valid=0; release -> resumes at addr 8.
//   3. Redirect to 0x40 while WAIT -> the next rsp is dropped, the next request addr=0x40,
//      and the first instr_pc after the redirect=0x40.
//   4. Redirect to 0x103 with the FIFO holding 2 entries -> FIFO empty next cycle, req addr=0x100.
//   5. Redirect coincident with rsp and pop -> popped instr delivered, rsp dropped, next addr=target.
//   6. Assert reset while WAIT, release -> req addr=RESET_PC, stale rsp not enqueued;
//      with FETCH_PERF_EN, counters=0.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: fetch PC, single-outstanding imem request, prefetch FIFO to decode.
// Optional FETCH_PERF_EN macro adds perf_fetched / perf_squashed counters.
module fetch_prefetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_squashed
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic [31:0]   head_data;
    logic [31:0]   head_pc;
    logic [31:0]   mem_data [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after_pop;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic          drop;

    assign imem_req_valid  = !reset && (state == ST_REQ) && (count < CW'(DEPTH));
    assign imem_req_addr   = reset ? '0 : fetch_pc;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign push            = (state == ST_WAIT) && imem_rsp_valid && !redirect_valid;
    assign drop            = imem_rsp_valid &&
                             ((state == ST_DRAIN) || ((state == ST_WAIT) && redirect_valid));
    assign instr_valid     = (count != '0);
    assign pop             = instr_valid && instr_ready;
    assign count_after_pop = count - CW'(pop);
    assign rd_next         = rd_ptr + PW'(pop);
    assign instr_data      = head_data;
    assign instr_pc        = head_pc;

    always_comb begin
        state_next = state;
        case (state)
            ST_REQ: begin
                if (req_fire) state_next = redirect_valid ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rsp_valid)      state_next = ST_REQ;
                else if (redirect_valid) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (imem_rsp_valid) state_next = ST_REQ;
            end
            default: state_next = ST_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= imem_rsp_data;
            mem_pc[wr_ptr]   <= inflight_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_REQ;
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            head_data   <= '0;
            head_pc     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            state <= state_next;
            if (req_fire) inflight_pc <= fetch_pc;
            if (redirect_valid)  fetch_pc <= redirect_pc & ~32'h3;
            else if (req_fire)   fetch_pc <= fetch_pc + 32'd4;
            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                rd_ptr <= rd_next;
                if (push) wr_ptr <= wr_ptr + PW'(1);
                count <= count_after_pop + CW'(push);
                // Head register tracks the next head; a push into an emptied FIFO goes straight to it.
                if (push && (count_after_pop == '0)) begin
                    head_data <= imem_rsp_data;
                    head_pc   <= inflight_pc;
                end else if (count_after_pop != '0) begin
                    head_data <= mem_data[rd_next];
                    head_pc   <= mem_pc[rd_next];
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched  <= '0;
            perf_squashed <= '0;
        end else begin
            if (push) perf_fetched <= perf_fetched + 32'd1;
            if (redirect_valid)
                perf_squashed <= perf_squashed + 32'(count_after_pop) + 32'(drop);
            else if (drop)
                perf_squashed <= perf_squashed + 32'd1;
        end
    end
`endif

endmodule
